nioslab2_onchip_loader: RTL



---
 rtl/nioslab2_onchip_loader_pkg.sv | 8 +
 rtl/nioslab2_onchip_loader_csum.sv | 19 +
 rtl/nioslab2_onchip_loader.sv | 129 ++++++++++++
 3 files changed

// File: rtl/nioslab2_onchip_loader_pkg.sv
// niosLab2_loader_pkg: shared types and constants for the on-chip RAM loader
package niosLab2_loader_pkg;
    localparam int ADDR_W = 13;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 8192;
    localparam logic [3:0] BE_ALL = 4'hF;
    typedef enum logic [2:0] {IDLE, WRITE, RD_ISSUE, RD_DRAIN, FINISH} loader_state_t;
endpackage

// File: rtl/nioslab2_onchip_loader_csum.sv
// niosLab2_loader_csum: clearable, enabled modulo-2^W accumulator
module niosLab2_loader_csum #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] sum_o
);
    logic [W-1:0] sum_q;
    // clear wins over accumulate so a new run never inherits the previous total
    always_ff @(posedge clk) begin
        if (reset || clr_i) sum_q <= '0;
        else if (en_i) sum_q <= sum_q + d_i;
    end
    assign sum_o = sum_q;
endmodule

// File: rtl/nioslab2_onchip_loader.sv
// nioslab2_onchip_loader: streams words into on-chip RAM with checksum and optional read-back verify
module nioslab2_onchip_loader
    import niosLab2_loader_pkg::*;
#(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [ADDR_W:0]       length,
    input  logic                  verify,
    input  logic [DATA_W-1:0]     snk_data,
    input  logic                  snk_valid,
    output logic                  snk_ready,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_W-1:0]     checksum,
    output logic [ADDR_W:0]       words_written,
    output logic                  verify_ok
);
    loader_state_t     state_q;
    logic [ADDR_W-1:0] base_q, ptr_q;
    logic [ADDR_W:0]   len_q, cnt_q, words_q;
    logic              verify_q, busy_q, done_q, ok_q, rd_vld_q;
    logic [DATA_W-1:0] wsum, rsum, rsum_d;
    logic              wr_fire, rd_issue, start_ok;

    assign start_ok = (state_q == IDLE) && start;
    assign wr_fire  = (state_q == WRITE) && snk_valid;
    assign rd_issue = (state_q == RD_ISSUE);
    assign rsum_d   = rsum + (rd_vld_q ? mem_readdata : '0);

    assign snk_ready      = (state_q == WRITE);
    assign mem_chipselect = wr_fire || rd_issue;
    assign mem_write      = wr_fire;
    assign mem_address    = ptr_q;
    assign mem_writedata  = wr_fire ? snk_data : '0;
    assign mem_byteenable = BE_ALL;
    assign mem_clken      = 1'b1;
    assign busy           = busy_q;
    assign done           = done_q;
    assign checksum       = wsum;
    assign words_written  = words_q;
    assign verify_ok      = ok_q;

    niosLab2_loader_csum #(.W(DATA_W)) u_wsum (
        .clk(clk), .reset(reset), .clr_i(start_ok), .en_i(wr_fire), .d_i(snk_data), .sum_o(wsum)
    );

    niosLab2_loader_csum #(.W(DATA_W)) u_rsum (
        .clk(clk), .reset(reset), .clr_i(start_ok), .en_i(rd_vld_q), .d_i(mem_readdata), .sum_o(rsum)
    );

    // run sequencer: capture, write stream, read-back issue/drain, one-cycle finish
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            base_q   <= '0;
            ptr_q    <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            words_q  <= '0;
            verify_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ok_q     <= 1'b0;
            rd_vld_q <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            rd_vld_q <= rd_issue;
            case (state_q)
                IDLE: if (start) begin
                    base_q   <= base_addr;
                    ptr_q    <= base_addr;
                    len_q    <= length;
                    verify_q <= verify;
                    words_q  <= '0;
                    cnt_q    <= '0;
                    if (length == '0) begin
                        state_q <= FINISH;
                        done_q  <= 1'b1;
                        ok_q    <= 1'b1;
                    end else begin
                        state_q <= WRITE;
                        busy_q  <= 1'b1;
                        ok_q    <= 1'b0;
                    end
                end
                WRITE: if (snk_valid) begin
                    ptr_q   <= ptr_q + ADDR_W'(1);
                    words_q <= words_q + (ADDR_W+1)'(1);
                    if (words_q + (ADDR_W+1)'(1) == len_q) begin
                        if (verify_q) begin
                            state_q <= RD_ISSUE;
                            ptr_q   <= base_q;
                        end else begin
                            state_q <= FINISH;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            ok_q    <= 1'b1;
                        end
                    end
                end
                RD_ISSUE: begin
                    ptr_q <= ptr_q + ADDR_W'(1);
                    cnt_q <= cnt_q + (ADDR_W+1)'(1);
                    if (cnt_q + (ADDR_W+1)'(1) == len_q) state_q <= RD_DRAIN;
                end
                RD_DRAIN: begin
                    state_q <= FINISH;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    ok_q    <= (rsum_d == wsum);
                end
                FINISH:  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
